soma_sinal_acumulador: RTL

- Parametrised, registered successor to the team's mixed signed/unsigned adder.
- Adds two operands of independent width. Signedness is selectable per operand and per result.
- Supports wrap or saturating arithmetic and a running accumulator.
- Sits between the operand source and the result consumer, with a valid/ready handshake on each side.

---
 rtl/soma_sinal_acumulador.sv | 102 ++++++++++
 1 files changed

// File: rtl/soma_sinal_acumulador.sv
// Registered mixed-signedness adder with wrap/saturate modes and accumulator.
// Ports: clk, rst (sync, active-high); operand side entrada_a/entrada_b,
//   sinal_a/sinal_b/sinal_saida, codigo, entrada_valida/entrada_pronta;
//   result side saida/estouro, saida_valida/saida_pronta.
module soma_sinal_acumulador #(
   parameter int LARGURA_A = 8,
   parameter int LARGURA_B = 4,
   parameter int LARGURA_S = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [LARGURA_A-1:0] entrada_a,
   input  logic [LARGURA_B-1:0] entrada_b,
   input  logic                 sinal_a,
   input  logic                 sinal_b,
   input  logic                 sinal_saida,
   input  logic [1:0]           codigo,
   input  logic                 entrada_valida,
   output logic                 entrada_pronta,
   output logic [LARGURA_S-1:0] saida,
   output logic                 estouro,
   output logic                 saida_valida,
   input  logic                 saida_pronta
);

   // Two guard bits hold any exact sum of two S+1-bit signed values.
   localparam int W = LARGURA_S + 2;

   typedef enum logic {VAZIO, CHEIO} estado_t;

   estado_t estado, estado_prox;

   logic [LARGURA_S-1:0] acumulador;
   logic [W-1:0]         ext_a, ext_b, ext_acc, parcela, soma;
   logic [LARGURA_S-1:0] satur, resultado;
   logic                 fora;
   logic                 xfer_in, xfer_out;

   assign entrada_pronta = !saida_valida || saida_pronta;
   assign xfer_in  = entrada_valida && entrada_pronta;
   assign xfer_out = saida_valida && saida_pronta;
   assign saida_valida = (estado == CHEIO);

   always_comb begin
      ext_a = sinal_a
         ? {{(W-LARGURA_A){entrada_a[LARGURA_A-1]}}, entrada_a}
         : {{(W-LARGURA_A){1'b0}}, entrada_a};
      ext_b = sinal_b
         ? {{(W-LARGURA_B){entrada_b[LARGURA_B-1]}}, entrada_b}
         : {{(W-LARGURA_B){1'b0}}, entrada_b};
      // Accumulator is reinterpreted under the current result signedness.
      ext_acc = sinal_saida
         ? {{(W-LARGURA_S){acumulador[LARGURA_S-1]}}, acumulador}
         : {{(W-LARGURA_S){1'b0}}, acumulador};
      parcela = (codigo == 2'b10) ? ext_acc : ext_b;
      soma    = ext_a + parcela;
   end

   // Signed fits when the top bits down to the result MSB all agree;
   // unsigned fits when everything above the result width is zero.
   always_comb begin
      if (sinal_saida) begin
         fora = !((&soma[W-1:LARGURA_S-1]) || !(|soma[W-1:LARGURA_S-1]));
         satur = soma[W-1] ? {1'b1, {(LARGURA_S-1){1'b0}}}
                           : {1'b0, {(LARGURA_S-1){1'b1}}};
      end else begin
         fora  = |soma[W-1:LARGURA_S];
         satur = soma[W-1] ? '0 : '1;
      end
      resultado = (codigo == 2'b01 && fora) ? satur : soma[LARGURA_S-1:0];
   end

   always_comb begin
      estado_prox = estado;
      unique case (estado)
         VAZIO: if (xfer_in) estado_prox = CHEIO;
         CHEIO: if (xfer_out && !xfer_in) estado_prox = VAZIO;
         default: estado_prox = VAZIO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado <= VAZIO;
      end else begin
         estado <= estado_prox;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         saida      <= '0;
         estouro    <= 1'b0;
         acumulador <= '0;
      end else if (xfer_in) begin
         saida   <= resultado;
         estouro <= fora;
         if (codigo[1]) acumulador <= resultado;
      end
   end

endmodule
